// File: rtl/seq_booth_divider.sv
// Sequential signed divider: restoring division on operand magnitudes,
// one quotient bit per clock, followed by a sign-correction cycle.
//
// Ports:
//   clk, reset        - clock and synchronous active-high reset
//   start             - request a division (sampled only when idle)
//   dividend, divisor - signed WIDTH-bit operands, sampled on accept
//   quotient          - signed quotient, truncated toward zero
//   remainder         - signed remainder, sign follows the dividend
//   busy              - high while a division is in progress
//   done              - one-cycle pulse when results become valid
//   div_by_zero       - last accepted divisor was zero
//   overflow          - last operation was most-negative / -1
module seq_booth_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
    localparam logic [WIDTH-1:0] ALL_ONES = '1;
    localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CW-1:0]    LAST     = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX
    } state_t;

    function automatic logic [WIDTH-1:0] neg(input logic [WIDTH-1:0] v);
        return ~v + ONE;
    endfunction

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    // Magnitude remainder is always < |divisor|, so WIDTH bits hold it;
    // the extra bit only exists in the trial subtraction below.
    logic [WIDTH-1:0] pr_q, pr_d;
    // Holds |dividend| at accept; quotient bits shift in from the right.
    logic [WIDTH-1:0] qr_q, qr_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic             sa_q, sa_d;
    logic             sb_q, sb_d;
    logic             zero_q, zero_d;
    logic             ovfp_q, ovfp_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             dbz_q, dbz_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH:0]   shift;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] abs_dvd;
    logic [WIDTH-1:0] abs_dvs;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pr_d        = pr_q;
        qr_d        = qr_q;
        dvs_d       = dvs_q;
        dvd_d       = dvd_q;
        sa_d        = sa_q;
        sb_d        = sb_q;
        zero_d      = zero_q;
        ovfp_d      = ovfp_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        dbz_d       = dbz_q;
        ovf_d       = ovf_q;

        shift   = {pr_q, qr_q[WIDTH-1]};
        diff    = shift - {1'b0, dvs_q};
        abs_dvd = dividend[WIDTH-1] ? neg(dividend) : dividend;
        abs_dvs = divisor[WIDTH-1] ? neg(divisor) : divisor;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    sa_d    = dividend[WIDTH-1];
                    sb_d    = divisor[WIDTH-1];
                    qr_d    = abs_dvd;
                    dvs_d   = abs_dvs;
                    dvd_d   = dividend;
                    pr_d    = '0;
                    cnt_d   = '0;
                    zero_d  = (divisor == '0);
                    ovfp_d  = (dividend == MIN_NEG) &&
                              (divisor == ALL_ONES);
                    dbz_d   = 1'b0;
                    ovf_d   = 1'b0;
                    busy_d  = 1'b1;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                // Top bit of diff set means the trial went negative.
                if (!diff[WIDTH]) begin
                    pr_d = diff[WIDTH-1:0];
                    qr_d = {qr_q[WIDTH-2:0], 1'b1};
                end else begin
                    pr_d = shift[WIDTH-1:0];
                    qr_d = {qr_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                quotient_d  = (sa_q ^ sb_q) ? neg(qr_q) : qr_q;
                remainder_d = sa_q ? neg(pr_q) : pr_q;
                if (zero_q) begin
                    quotient_d  = ALL_ONES;
                    remainder_d = dvd_q;
                end
                // MIN_NEG / -1 already wraps to MIN_NEG with zero
                // remainder; only the flag needs raising.
                dbz_d   = zero_q;
                ovf_d   = ovfp_q;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            pr_q        <= '0;
            qr_q        <= '0;
            dvs_q       <= '0;
            dvd_q       <= '0;
            sa_q        <= 1'b0;
            sb_q        <= 1'b0;
            zero_q      <= 1'b0;
            ovfp_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            dbz_q       <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pr_q        <= pr_d;
            qr_q        <= qr_d;
            dvs_q       <= dvs_d;
            dvd_q       <= dvd_d;
            sa_q        <= sa_d;
            sb_q        <= sb_d;
            zero_q      <= zero_d;
            ovfp_q      <= ovfp_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            dbz_q       <= dbz_d;
            ovf_q       <= ovf_d;
        end
    end

    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign overflow    = ovf_q;

endmodule

// File: doc/seq_booth_divider.md
Name: seq_booth_divider

Overview:
- Sequential signed integer divider; the inverse operation of the combinational Booth multiplier in the arithmetic datapath.
- Takes a two's-complement dividend and divisor, iterates one quotient bit per clock (restoring division on magnitudes), then applies sign correction.
- Returns quotient and remainder through a start/busy/done handshake.
- Used by the ALU/lab datapath wherever a multiply result must be divided back or a general division is needed.

Parameters:
- WIDTH, 8, bit width of dividend, divisor, quotient and remainder (two's complement); legal range 2..32.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a division; sampled only in IDLE.
- dividend  input  WIDTH  signed dividend; sampled on the accepting edge.
- divisor  input  WIDTH  signed divisor; sampled on the accepting edge.
- quotient  output  WIDTH  signed quotient, truncated toward zero.
- remainder  output  WIDTH  signed remainder; sign follows the dividend.
- busy  output  1  high while a division is in progress.
- done  output  1  one-cycle pulse when quotient/remainder become valid.
- div_by_zero  output  1  sticky-until-next-start flag: last divisor was 0.
- overflow  output  1  sticky-until-next-start flag: most-negative / -1.

Behaviour:
- Reset: clk and reset are one clock; reset is synchronous and active-high. On reset all outputs go to 0, state goes to IDLE, and internal registers are cleared.
- Reset mid-operation aborts the division. No done pulse is produced and the old results are lost, because outputs are 0.
- States:
  - IDLE: wait for start.
  - CALC: WIDTH iterations.
  - FIX: sign correction and output register load.
  - Return to IDLE.
- IDLE, start=1 at edge k:
  - Latch the sign of the dividend, the sign of the divisor, |dividend| and |divisor| as WIDTH-bit unsigned values. |most-negative| = 2^(WIDTH-1) fits unsigned.
  - Clear the partial remainder (WIDTH+1 bits) and the iteration counter.
  - Clear div_by_zero and overflow.
  - Go to CALC; busy=1 from cycle k+1.
- CALC, one iteration per edge (k+1 .. k+WIDTH):
  - Shift {partial remainder, quotient register} left by 1, bringing in the next dividend MSB.
  - Trial-subtract |divisor|.
  - If the result is non-negative, keep it and set quotient bit = 1; otherwise restore and set quotient bit = 0.
  - After the WIDTH-th iteration, go to FIX.
- FIX, edge k+WIDTH+1:
  - quotient = magnitude quotient, negated if the operand signs differ.
  - remainder = magnitude remainder, negated if the dividend is negative.
  - done=1 for exactly this one cycle; busy=0 on the same edge; go to IDLE.
- Latency: start is accepted at edge k and done is visible in the cycle after edge k+WIDTH+1, so latency is WIDTH+1 cycles. Latency is constant for all operands, including the special cases.
- Results hold stable after done until the next accepted start.
- quotient and remainder registers are updated only in FIX; they are not updated during CALC.
- Divisor = 0:
  - Iterations still run, so latency is unchanged.
  - FIX forces quotient = all ones (-1), remainder = dividend (original signed value), div_by_zero=1.
- Dividend = -2^(WIDTH-1) and divisor = -1:
  - quotient = -2^(WIDTH-1) (wraps), remainder = 0, overflow=1.
- start while busy is ignored. Operands are not re-sampled and no queueing is done.
- start held high continuously: a new division is accepted in the cycle after done, i.e. back-to-back every WIDTH+2 cycles.
- start asserted in the same cycle as reset: reset wins and the state stays IDLE.
- Arithmetic: all negations are two's complement at WIDTH bits. Invariant: dividend == quotient*divisor + remainder (mod 2^WIDTH), with |remainder| < |divisor| when divisor ≠ 0.

Test Plan:
- WIDTH=8, 100 / 7 -> quotient=14, remainder=2, done exactly 9 cycles after start accepted, flags 0.
- -100 / 7 -> quotient=-14 (8'hF2), remainder=-2 (8'hFE); 100 / -7 -> quotient=-14, remainder=2; -100 / -7 -> quotient=14, remainder=-2.
- -128 / -1 -> quotient=8'h80, remainder=0, overflow=1; next start with 6 / 3 -> overflow cleared, quotient=2, remainder=0.
- 5 / 0 -> quotient=8'hFF, remainder=5, div_by_zero=1, latency still 9 cycles.
- Start 50 / 5, pulse start again with 9 / 2 at cycle 3 -> second request ignored, result quotient=10, remainder=0; assert reset at cycle 4 of a new 77 / 3 -> no done, all outputs 0, then 77 / 3 -> quotient=25, remainder=2.
- Random sweep of 10,000 operand pairs (divisor ≠ 0, excluding -128/-1) vs reference model -> invariant holds, |remainder| < |divisor|, remainder sign equals dividend sign or remainder=0.
